// File: rtl/ca_correlator_if.sv
// ----------------------------------------------------------------------------
// ca_correlator_if
//
// Bundles the correlator's code/sample input stream and its correlation
// output register into one interface.
//
//   chip_en, ca_code          code generator strobe and the new chip
//   sample_valid, sample_i/q  baseband I/Q samples (signed, SAMPLE_W)
//   corr_valid, corr_ready    output handshake
//   ie, qe, ip, qp, il, ql    early/prompt/late I/Q correlations (signed, ACC_W)
//   overrun                   sticky flag: a dump was lost
//
// Handshake: a set transfers on a cycle where corr_valid and corr_ready are
// both high. While corr_valid is high and corr_ready is low, the producer
// holds corr_valid and all six correlations stable. corr_ready may be high
// while corr_valid is low; that has no effect.
//
// Modports:
//   slave  - the correlator (consumes the stream, drives the correlations)
//   master - whoever drives the stream and consumes the correlations
// ----------------------------------------------------------------------------
interface ca_correlator_if #(
    parameter int SAMPLE_W = 4,
    parameter int ACC_W    = 16
);
    logic                       chip_en;
    logic                       ca_code;
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample_i;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic                       corr_valid;
    logic                       corr_ready;
    logic signed [ACC_W-1:0]    ie;
    logic signed [ACC_W-1:0]    qe;
    logic signed [ACC_W-1:0]    ip;
    logic signed [ACC_W-1:0]    qp;
    logic signed [ACC_W-1:0]    il;
    logic signed [ACC_W-1:0]    ql;
    logic                       overrun;

    modport slave (
        input  chip_en, ca_code, sample_valid, sample_i, sample_q, corr_ready,
        output corr_valid, ie, qe, ip, qp, il, ql, overrun
    );

    modport master (
        output chip_en, ca_code, sample_valid, sample_i, sample_q, corr_ready,
        input  corr_valid, ie, qe, ip, qp, il, ql, overrun
    );
endinterface

// File: rtl/ca_correlator.sv
// ----------------------------------------------------------------------------
// ca_correlator
//
// Early/prompt/late correlator placed directly after the C/A code generator.
// The incoming chip stream is delayed through three registers (early, prompt,
// late). Every valid I/Q sample is multiplied by +1/-1 according to each of
// the three chips and added, with saturation, into six accumulators. After
// CODE_LEN chips (the epoch) the six sums are dumped into a valid/ready
// output register and the accumulators restart from zero.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   clear  synchronous clear of all state, highest priority
//   bus    ca_correlator_if.slave (stream in, correlations out, overrun)
//
// Parameters:
//   SAMPLE_W  signed sample width (must not exceed ACC_W)
//   ACC_W     signed accumulator / output width
//   CODE_LEN  chips per integration period, 2..1023
// ----------------------------------------------------------------------------
module ca_correlator #(
    parameter int SAMPLE_W = 4,
    parameter int ACC_W    = 16,
    parameter int CODE_LEN = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    ca_correlator_if.slave   bus
);
    localparam int CNT_W = $clog2(CODE_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CODE_LEN - 1);

    // Saturation limits expressed one bit wider than the accumulator so the
    // raw sum can be compared before it is narrowed.
    localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    // Accumulator / output slot order: 0 ie, 1 qe, 2 ip, 3 qp, 4 il, 5 ql.
    localparam int N_CORR = 6;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                    e_q, e_d;
    logic                    p_q, p_d;
    logic                    l_q, l_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q [N_CORR];
    logic signed [ACC_W-1:0] acc_d [N_CORR];
    logic signed [ACC_W-1:0] out_q [N_CORR];
    logic signed [ACC_W-1:0] out_d [N_CORR];
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    // Combinational helpers
    logic                    epoch;
    logic                    code_sel [N_CORR];
    logic signed [SAMPLE_W-1:0] smp_sel [N_CORR];
    logic signed [ACC_W-1:0] sum_v [N_CORR];

    // Adds +s (neg=0) or -s (neg=1) to a and clamps to the ACC_W range.
    // The sum is formed in ACC_W+1 bits: negating the most negative sample
    // and adding it to a full-scale accumulator both fit there.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0]    a,
        input logic signed [SAMPLE_W-1:0] s,
        input logic                       neg
    );
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] sum;
        ext = (ACC_W+1)'(s);
        if (neg) begin
            ext = -ext;
        end
        sum = (ACC_W+1)'(a) + ext;
        if (sum > SUM_MAX) begin
            return SUM_MAX[ACC_W-1:0];
        end else if (sum < SUM_MIN) begin
            return SUM_MIN[ACC_W-1:0];
        end else begin
            return sum[ACC_W-1:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        e_d       = e_q;
        p_d       = p_q;
        l_d       = l_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        // The epoch is the chip_en that would take the count past CODE_LEN-1.
        epoch = bus.chip_en && (cnt_q == CNT_LAST);

        // Each slot picks its chip (pre-update e/p/l of this cycle) and its
        // sample rail. A 0 chip means +1, a 1 chip means -1.
        for (int k = 0; k < N_CORR; k++) begin
            code_sel[k] = (k < 2) ? e_q : ((k < 4) ? p_q : l_q);
            smp_sel[k]  = (k % 2 == 0) ? bus.sample_i : bus.sample_q;
            sum_v[k]    = bus.sample_valid ? sat_add(acc_q[k], smp_sel[k], code_sel[k])
                                           : acc_q[k];
            // The epoch cycle's sample is already in sum_v, which becomes
            // the dump; the accumulators then start the next period at 0.
            acc_d[k]    = epoch ? '0 : sum_v[k];
            out_d[k]    = out_q[k];
        end

        if (bus.chip_en) begin
            e_d   = bus.ca_code;
            p_d   = e_q;
            l_d   = p_q;
            cnt_d = epoch ? '0 : cnt_q + CNT_W'(1);
        end

        // Output register. A set still pending with no taker when the next
        // dump arrives is kept, and the new one is dropped and flagged.
        if (epoch) begin
            if (!valid_q || bus.corr_ready) begin
                for (int k = 0; k < N_CORR; k++) begin
                    out_d[k] = sum_v[k];
                end
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.corr_ready) begin
            valid_d = 1'b0;
        end

        if (clear) begin
            e_d       = 1'b0;
            p_d       = 1'b0;
            l_d       = 1'b0;
            cnt_d     = '0;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
            for (int k = 0; k < N_CORR; k++) begin
                acc_d[k] = '0;
                out_d[k] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q       <= 1'b0;
            p_q       <= 1'b0;
            l_q       <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < N_CORR; k++) begin
                acc_q[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            e_q       <= e_d;
            p_q       <= p_d;
            l_q       <= l_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            for (int k = 0; k < N_CORR; k++) begin
                acc_q[k] <= acc_d[k];
                out_q[k] <= out_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.corr_valid = valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.ie         = out_q[0];
    assign bus.qe         = out_q[1];
    assign bus.ip         = out_q[2];
    assign bus.qp         = out_q[3];
    assign bus.il         = out_q[4];
    assign bus.ql         = out_q[5];

endmodule

// File: doc/ca_correlator.md
Name: ca_correlator

Overview:
- Early/prompt/late correlator stage directly downstream of the C/A code generator.
- Takes the generator's chip stream and chip-advance strobe, plus baseband I/Q samples from the front-end.
- Wipes the code off the samples and integrates over one code period (CODE_LEN chips).
- At each period boundary, dumps six accumulated correlations to the tracking loop through a valid/ready output register.

Parameters:
- SAMPLE_W, 4: signed width of sample_i/sample_q (two's complement).
- ACC_W, 16: signed width of each accumulator and each output correlation.
- CODE_LEN, 1023: chips per integration period; legal range 2..1023.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all state; equivalent to reset but takes effect at the clock edge.
- chip_en  in  1  code generator advanced this cycle; ca_code carries the new chip.
- ca_code  in  1  current C/A chip; 0 maps to +1, 1 maps to -1.
- sample_valid  in  1  sample_i/sample_q valid this cycle.
- sample_i  in  SAMPLE_W  signed in-phase sample.
- sample_q  in  SAMPLE_W  signed quadrature sample.
- corr_valid  out  1  output correlation set valid.
- corr_ready  in  1  consumer accepts output set.
- ie, qe, ip, qp, il, ql  out  ACC_W each  signed early/prompt/late I and Q correlations.
- overrun  out  1  sticky flag: a dump was lost.

Behaviour:
Reset (rst_n low) or clear high:
- Accumulators, chip counter, code registers e/p/l, corr_valid, overrun and all six outputs are 0.
- clear has priority over every other event in the same cycle.
- Reset asserted mid-integration discards the partial sums with no dump.

Code delay line:
- On chip_en: e <= ca_code, p <= e, l <= p.
- Early leads prompt by 1 chip; late lags prompt by 1 chip.
- Registers update only on chip_en.

Accumulation:
- On sample_valid, each accumulator adds +sample or -sample according to the pre-update e/p/l value of the current cycle.
- I accumulators use sample_i; Q accumulators use sample_q.
- Each addition saturates to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1]; there is no wrap.

Chip counter:
- Counts chip_en events from 0 to CODE_LEN-1.
- A chip_en while count==CODE_LEN-1 is the epoch event; the count returns to 0.

Dump (epoch event):
- The six accumulator values, including any sample added in that same cycle, are the dump set.
- Accumulators restart at 0 on the next cycle, so no sample is lost or double-counted.
- Dump latency: outputs and corr_valid update on the edge that processes the epoch chip_en.

Output handshake:
- Transfer occurs when corr_valid and corr_ready are both high.
- corr_valid and the outputs are held stable until transfer.
- Dump while corr_valid=0, or while corr_valid=1 and corr_ready=1: load the new set and keep corr_valid=1.
- Dump while corr_valid=1 and corr_ready=0: the new set is dropped, the old set is held, and overrun is set.
- corr_ready with no dump and corr_valid=1: corr_valid goes to 0 next cycle.
- overrun stays set until reset or clear.

Other rules:
- chip_en with no sample_valid is legal: the code advances and nothing is accumulated.
- sample_valid with no chip_en is legal: multiple samples per chip are accumulated.
- ca_code is ignored when chip_en=0.

Test Plan:
- Reset, then 1023 cycles with chip_en=1, ca_code=0, sample_valid=1, sample_i=3, sample_q=-2 -> a single dump with ip=ie=il=3069 and qp=qe=ql=-2046 (e/l start from reset 0 = +1); corr_valid=1, overrun=0.
- Drive the prompt code equal to a ±1 pattern and samples = +4 × the chip sign -> ip=4092; ie/il reflect the ±1-chip shifted autocorrelation; checked against a bench model.
- ACC_W=12, sample_i=7 on every chip -> ip saturates at 2047 and does not wrap negative; sample_i=-8 -> -2048.
- corr_ready held 0 across two epochs -> first set held unchanged, overrun=1 after the second epoch event; clear -> corr_valid=0, overrun=0, outputs 0.
- Dump cycle coincident with corr_ready=1 and corr_valid=1 -> new set loaded, corr_valid stays 1, no overrun; sample in the epoch cycle counted in the old dump only.
- rst_n pulsed low at chip 500, then 1023 chips -> exactly one dump containing only post-reset samples.
